// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode type for gray_counter_n and
// the clock-domain-crossing pointer logic that reuses the decoder.
package gray_pkg;

  localparam int GRAY_MAX_W = 16;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits of narrower operands are zero, so the prefix XOR is width-agnostic.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above it.
module gray2bin_dec #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^g_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter_n.sv
// N-bit reflected-binary Gray counter with up/down, synchronous load and
// wrap or saturate behaviour at the extremes.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int SATURATE  = 0,
  parameter int RESET_BIN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_bin,
  output logic             tc,
  output logic             wrapped,
  output logic             saturated
);

  localparam cnt_mode_e MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  localparam logic [WIDTH-1:0] MAX_BIN = '1;
  localparam logic [GRAY_MAX_W-1:0] RESET_G_FULL = bin2gray(GRAY_MAX_W'(RESET_BIN));
  localparam logic [WIDTH-1:0] RESET_G = RESET_G_FULL[WIDTH-1:0];

  logic [WIDTH-1:0]      g_q, g_d;
  logic                  wrapped_q, wrapped_d;
  logic                  sat_q, sat_d;
  logic [WIDTH-1:0]      next_bin;
  logic [GRAY_MAX_W-1:0] next_g_full, load_g_full;
  logic                  at_max, at_min, wrap_step, load_extreme;

  gray2bin_dec #(.WIDTH(WIDTH)) u_dec (
    .g_i  (g_q),
    .bin_o(count_bin)
  );

  assign at_max       = (count_bin == MAX_BIN);
  assign at_min       = (count_bin == '0);
  assign wrap_step    = up ? at_max : at_min;
  assign tc           = en & ~load & wrap_step;
  assign next_bin     = up ? count_bin + WIDTH'(1) : count_bin - WIDTH'(1);
  assign next_g_full  = bin2gray(GRAY_MAX_W'(next_bin));
  assign load_g_full  = bin2gray(GRAY_MAX_W'(load_bin));
  assign load_extreme = (load_bin == '0) || (load_bin == MAX_BIN);

  // NOTE: every output of always_comb gets a default first so no latch is inferred.
  always_comb begin
    g_d       = g_q;
    wrapped_d = 1'b0;
    sat_d     = sat_q;
    if (load) begin
      g_d   = load_g_full[WIDTH-1:0];
      sat_d = (MODE == CNT_SAT) && load_extreme;
    end else if (en) begin
      if (wrap_step && (MODE == CNT_SAT)) begin
        sat_d = 1'b1;
      end else begin
        g_d       = next_g_full[WIDTH-1:0];
        wrapped_d = wrap_step;
        sat_d     = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments; reset here is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      g_q       <= RESET_G;
      wrapped_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      g_q       <= g_d;
      wrapped_q <= wrapped_d;
      sat_q     <= sat_d;
    end
  end

  assign count     = g_q;
  assign wrapped   = wrapped_q;
  assign saturated = sat_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Self-checking bench for gray_counter_n: directed wrap/saturate/load/reset
// cases plus a randomized run against an integer reference model.
module tb_gray_counter_n;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [15:0] lb;

  logic [2:0] c3w, cb3w, c3s, cb3s;
  logic [7:0] c8, cb8;
  logic [4:0] c5, cb5;
  logic tc3w, wr3w, sat3w, tc3s, wr3s, sat3s, tc8, wr8, sat8, tc5, wr5, sat5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(3), .SATURATE(0)) d3w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_bin(lb[2:0]),
    .count(c3w), .count_bin(cb3w), .tc(tc3w), .wrapped(wr3w), .saturated(sat3w));

  gray_counter_n #(.WIDTH(3), .SATURATE(1)) d3s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_bin(lb[2:0]),
    .count(c3s), .count_bin(cb3s), .tc(tc3s), .wrapped(wr3s), .saturated(sat3s));

  gray_counter_n #(.WIDTH(8), .SATURATE(0)) d8 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_bin(lb[7:0]),
    .count(c8), .count_bin(cb8), .tc(tc8), .wrapped(wr8), .saturated(sat8));

  gray_counter_n #(.WIDTH(5), .SATURATE(0)) d5 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_bin(lb[4:0]),
    .count(c5), .count_bin(cb5), .tc(tc5), .wrapped(wr5), .saturated(sat5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [2:0] prev3;
    logic [4:0] prev5;
    int mb, e_bin, e_wr;
    logic e_tc;

    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lb = '0;
    #1;
    tick();
    reset = 1'b0;
    check("rst_count", 32'(c3w), 32'(0));
    check("rst_bin", 32'(cb3w), 32'(0));
    check("rst_wrapped", 32'(wr3w), 32'(0));
    check("rst_sat", 32'(sat3s), 32'(0));

    // Count up: wrap counter laps once, saturating counter pins at 7.
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("up_tc", 32'(tc3w), 32'(i == 7));
      prev3 = c3w;
      tick();
      check("up_count", 32'(c3w), 32'(gray_of((i + 1) % 8)));
      check("up_onebit", 32'($countones(prev3 ^ c3w)), 32'(1));
      check("up_wrapped", 32'(wr3w), 32'(i == 7));
      check("sat_bin", 32'(cb3s), 32'((i + 1 < 7) ? i + 1 : 7));
      check("sat_flag", 32'(sat3s), 32'(i >= 7));
      check("sat_nowrap", 32'(wr3s), 32'(0));
    end
    up = 1'b0;
    tick();
    check("sat_leave_count", 32'(c3s), 32'(3'b101));
    check("sat_leave_flag", 32'(sat3s), 32'(0));

    // Count down from reset.
    en = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    check("dn_tc_first", 32'(tc3w), 32'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dn_count", 32'(c3w), 32'(gray_of(7 - i)));
      check("dn_wrapped", 32'(wr3w), 32'(i == 0));
    end

    // Load with en high: load wins; then one up step.
    load = 1'b1; lb = 16'd200; en = 1'b1; up = 1'b1;
    tick();
    check("ld8_count", 32'(c8), 32'h0AC);
    check("ld8_bin", 32'(cb8), 32'd200);
    check("ld8_wrapped", 32'(wr8), 32'(0));
    load = 1'b0;
    tick();
    check("ld8_step_bin", 32'(cb8), 32'd201);
    check("ld8_step_count", 32'(c8), 32'h0AD);

    // Hold keeps count and clears wrapped.
    en = 1'b0;
    tick();
    check("hold_count", 32'(c8), 32'h0AD);

    // Loading an extreme in saturate mode flags saturated immediately.
    load = 1'b1; lb = 16'd7;
    tick();
    check("satld_flag", 32'(sat3s), 32'(1));
    check("satld_count", 32'(c3s), 32'(3'b100));
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    check("satld_leave", 32'(sat3s), 32'(0));
    check("satld_bin", 32'(cb3s), 32'(6));

    // Reset overrides simultaneous load and en.
    load = 1'b1; lb = 16'd5; en = 1'b0;
    tick();
    check("pre_rst_bin", 32'(cb3w), 32'(5));
    reset = 1'b1; load = 1'b1; lb = 16'd3; en = 1'b1;
    tick();
    check("rst_ovr_count", 32'(c3w), 32'(0));
    check("rst_ovr_wrapped", 32'(wr3w), 32'(0));
    check("rst_ovr_sat", 32'(sat3s), 32'(0));
    reset = 1'b0; load = 1'b0; en = 1'b0;

    // Randomized run on the 5-bit counter against an integer model.
    mb = 0;
    for (int n = 0; n < 10000; n++) begin
      load = ($urandom_range(0, 7) == 0);
      en   = 1'($urandom);
      up   = 1'($urandom);
      lb   = 16'($urandom_range(0, 31));
      #1;
      e_tc = en && !load && ((up && mb == 31) || (!up && mb == 0));
      check("rnd_tc", 32'(tc5), 32'(e_tc));
      e_wr = 0;
      if (load) begin
        e_bin = int'(lb);
      end else if (en) begin
        e_bin = (mb + (up ? 1 : 31)) % 32;
        e_wr  = int'(e_tc);
      end else begin
        e_bin = mb;
      end
      prev5 = c5;
      tick();
      mb = e_bin;
      check("rnd_bin", 32'(cb5), 32'(mb));
      check("rnd_count", 32'(c5), 32'(gray_of(mb)));
      check("rnd_wrapped", 32'(wr5), 32'(e_wr));
      if (!load && en) check("rnd_onebit", 32'($countones(prev5 ^ c5)), 32'(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
